// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient on lo, remainder on hi, busy/result_valid decoded from the FSM state.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  input  logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qs;
  logic             r_rs;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_div0;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_lo_final;
  logic [WIDTH-1:0] w_hi_final;

  assign w_accept  = start & ~annul;
  assign w_div0    = (divisor == '0);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_dvd_abs = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_abs = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;

  // Partial remainder is WIDTH+1 bits; the top bit of the difference is the borrow,
  // so no trial bit is ever lost when the divisor has its MSB set.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_dvsr};
  assign w_ge       = ~w_sub[WIDTH];
  assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  assign w_lo_final = r_qs ? -w_quo_next : w_quo_next;
  assign w_hi_final = r_rs ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_div0 ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (annul) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_qs   <= 1'b0;
      r_rs   <= 1'b0;
      r_cnt  <= '0;
      lo     <= '0;
      hi     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_div0) begin
              lo <= '1;
              hi <= dividend;
            end else begin
              r_rem  <= '0;
              r_quo  <= w_dvd_abs;
              r_dvsr <= w_dvs_abs;
              r_qs   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_rs   <= is_signed & dividend[WIDTH-1];
              r_cnt  <= '0;
            end
          end
        end
        S_CALC: begin
          if (!annul) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              lo <= w_lo_final;
              hi <= w_hi_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, stall hold, ignored starts and asynchronous reset mid-operation.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .lo           (lo),
    .hi           (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Optionally waits for a negedge, presents one start, and returns at the negedge
  // of the first result_valid cycle with lat = cycles after the accepting edge.
  task automatic run_op(input bit wait_first, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    if (wait_first) @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (result_valid) break;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout: result_valid=%b after %0d cycles, required 1", result_valid, lat);
    end
  endtask

  task automatic check_res(input string name, input int lat, input int exp_lat,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h, required %h", name, lo, exp_lo);
    end
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h, required %h", name, hi, exp_hi);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    annul = 1'b0; stall = 1'b0;
    #12;
    checks++;
    if ({busy, result_valid} !== 2'b00 || lo !== 32'h0 || hi !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b lo=%h hi=%h, required 0 0 0 0",
               busy, result_valid, lo, hi);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_divu_basic();
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || result_valid !== (c == 33)) begin
        errors++;
        $display("FAIL divu_cycle%0d: busy=%b valid=%b, required 1 %b", c, busy, result_valid, c == 33);
      end
    end
    check_res("divu_100_7", 33, 33, 32'd14, 32'd2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL divu_return_idle: busy=%b valid=%b, required 0 0", busy, result_valid);
    end
  endtask

  task automatic test_signed();
    int lat;
    run_op(1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    check_res("div_m7_2", lat, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    check_res("div_7_m2", lat, 33, 32'hFFFF_FFFD, 32'd1);
    run_op(1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat);
    check_res("div_m100_m7", lat, 33, 32'd14, 32'hFFFF_FFFE);
  endtask

  task automatic test_boundary();
    int lat;
    run_op(1, 1'b0, 32'hFFFF_FFFF, 32'd1, lat);
    check_res("divu_max_1", lat, 33, 32'hFFFF_FFFF, 32'd0);
    run_op(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check_res("div_overflow", lat, 33, 32'h8000_0000, 32'd0);
    run_op(1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check_res("divu_big_divisor", lat, 33, 32'd0, 32'h8000_0000);
    run_op(1, 1'b0, 32'hFFFF_FFFE, 32'h8000_0001, lat);
    check_res("divu_msb_divisor", lat, 33, 32'd1, 32'h7FFF_FFFD);
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1, 1'b1, 32'hFFFF_FFFB, 32'd0, lat);
    check_res("div_m5_0", lat, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op(1, 1'b0, 32'd5, 32'd0, lat);
    check_res("divu_5_0", lat, 1, 32'hFFFF_FFFF, 32'd5);
  endtask

  task automatic test_annul();
    int lat;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL annul_calc%0d: busy=%b valid=%b, required 1 0", c, busy, result_valid);
      end
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle: busy=%b valid=%b, required 0 0", busy, result_valid);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      errors++;
      $display("FAIL annul_hold: lo=%h hi=%h, required ffffffff 00000005", lo, hi);
    end
    run_op(0, 1'b0, 32'd1000, 32'd3, lat);
    check_res("after_annul", lat, 33, 32'd333, 32'd1);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    lat = 5;
    while (lat < 40 && !result_valid) begin
      @(negedge clk);
      lat++;
    end
    check_res("start_in_calc", lat, 33, 32'd10, 32'd0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b, required 0", busy);
    end
    start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    checks++;
    if (busy !== 1'b0 || lo !== 32'd10) begin
      errors++;
      $display("FAIL start_with_annul: busy=%b lo=%h, required 0 0000000a", busy, lo);
    end
  endtask

  task automatic test_stall();
    int lat;
    stall = 1'b1;
    run_op(1, 1'b0, 32'd77, 32'd10, lat);
    check_res("stall_op", lat, 33, 32'd7, 32'd7);
    annul = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b1 || lo !== 32'd7) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b busy=%b lo=%h, required 1 1 00000007",
                 c, result_valid, busy, lo);
      end
    end
    stall = 1'b0; annul = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b busy=%b, required 0 0", result_valid, busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd123; divisor = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, result_valid} !== 2'b00 || lo !== 32'h0 || hi !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%b valid=%b lo=%h hi=%h, required 0 0 0 0",
               busy, result_valid, lo, hi);
    end
    @(negedge clk); resetn = 1'b1;
    run_op(1, 1'b0, 32'd20, 32'd6, lat);
    check_res("after_reset", lat, 33, 32'd3, 32'd2);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_boundary();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_stall();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
